// File: rtl/niosii_buts_ctrl.sv
// Avalon-MM push-button port: 2-flop synchroniser, per-bit debounce, sticky edge capture and maskable irq.
// Define NIOSII_BUTS_ANY_EDGE_EN to capture release edges as well as presses.
module niosii_buts_ctrl #(
    parameter int WIDTH      = 8,
    parameter int DB_BITS    = 16,
    parameter int DB_DEFAULT = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [DB_BITS-1:0] DB_RESET = DB_BITS'(DB_DEFAULT);

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK  = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP  = 2'd2;
    localparam logic [1:0] ADDR_DBPERIOD = 2'd3;

    logic [WIDTH-1:0]   sync1_q, sync2_q;
    logic [WIDTH-1:0]   stable_q, stable_d;
    logic [DB_BITS-1:0] cnt_q [WIDTH];
    logic [DB_BITS-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0]   edgecap_q, edgecap_d;
    logic [WIDTH-1:0]   irqmask_q, irqmask_d;
    logic [DB_BITS-1:0] dbperiod_q, dbperiod_d;
    logic [31:0]        readdata_q, readdata_d;
    logic               irq_q, irq_d;

    logic               wr_en;
    logic [DB_BITS-1:0] eff_last;
    logic [WIDTH-1:0]   edge_set, edge_clr;
    logic [31:0]        data_word, mask_word, edge_word, period_word;
    logic               unused_wdata;

    assign unused_wdata = ^writedata;
    assign wr_en        = chipselect & ~write_n;

    // A period of 0 behaves like 1, so the terminal count is never below zero.
    always_comb begin
        eff_last = '0;
        if (dbperiod_q != '0) begin
            eff_last = dbperiod_q - DB_BITS'(1);
        end
    end

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != stable_q[i]) begin
                if (cnt_q[i] >= eff_last) begin
                    stable_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + DB_BITS'(1);
                end
            end
        end
    end

`ifdef NIOSII_BUTS_ANY_EDGE_EN
    assign edge_set = stable_q ^ stable_d;
`else
    assign edge_set = stable_q & ~stable_d;
`endif

    // A new edge in the same cycle as a W1C clear keeps the flag set.
    always_comb begin
        edge_clr   = '0;
        irqmask_d  = irqmask_q;
        dbperiod_d = dbperiod_q;
        if (wr_en) begin
            case (address)
                ADDR_IRQMASK:  irqmask_d  = writedata[WIDTH-1:0];
                ADDR_EDGECAP:  edge_clr   = writedata[WIDTH-1:0];
                ADDR_DBPERIOD: dbperiod_d = writedata[DB_BITS-1:0];
                default:       ;
            endcase
        end
        edgecap_d = (edgecap_q & ~edge_clr) | edge_set;
        irq_d     = |(edgecap_d & irqmask_d);
    end

    always_comb begin
        data_word   = '0;
        mask_word   = '0;
        edge_word   = '0;
        period_word = '0;
        data_word[WIDTH-1:0]     = stable_q;
        mask_word[WIDTH-1:0]     = irqmask_q;
        edge_word[WIDTH-1:0]     = edgecap_q;
        period_word[DB_BITS-1:0] = dbperiod_q;
        case (address)
            ADDR_DATA:     readdata_d = data_word;
            ADDR_IRQMASK:  readdata_d = mask_word;
            ADDR_EDGECAP:  readdata_d = edge_word;
            default:       readdata_d = period_word;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '1;
            sync2_q    <= '1;
            stable_q   <= '1;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            edgecap_q  <= '0;
            irqmask_q  <= '0;
            dbperiod_q <= DB_RESET;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            edgecap_q  <= edgecap_d;
            irqmask_q  <= irqmask_d;
            dbperiod_q <= dbperiod_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_niosii_buts_ctrl.sv
// Directed self-checking bench for niosii_buts_ctrl with hand-computed expectations.
module tb_niosii_buts_ctrl;

    logic        clk;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  in_port;
    logic        irq;

    int vectors;
    int miscompares;
    logic [31:0] rd;

    niosii_buts_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .irq        (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] buttons);
        in_port = buttons;
    endtask

    task automatic busWrite(input logic [1:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic busRead(input logic [1:0] addr, output logic [31:0] data);
        address = addr;
        tick(1);
        data = readdata;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        address     = 2'd0;
        chipselect  = 1'b0;
        write_n     = 1'b1;
        writedata   = 32'h0;
        in_port     = 8'hFF;

        // reset values
        tick(2);
        checkOutput("rst_readdata", readdata, 32'h0);
        checkOutput("rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        busRead(2'd0, rd); checkOutput("rst_data", rd, 32'h0000_00FF);
        busRead(2'd1, rd); checkOutput("rst_mask", rd, 32'h0);
        busRead(2'd2, rd); checkOutput("rst_edge", rd, 32'h0);
        busRead(2'd3, rd); checkOutput("rst_period", rd, 32'd50000);
        checkOutput("rst_irq2", {31'h0, irq}, 32'h0);

        // glitch of 3 cycles with period 4 is rejected
        busWrite(2'd3, 32'd4);
        busRead(2'd3, rd); checkOutput("period_rb", rd, 32'd4);
        address = 2'd0;
        applyStimulus(8'hFE);
        tick(3);
        applyStimulus(8'hFF);
        tick(10);
        checkOutput("glitch_data", readdata, 32'h0000_00FF);
        busRead(2'd2, rd); checkOutput("glitch_edge", rd, 32'h0);

        // held press: stable at the 6th edge, visible on DATA one read later
        busWrite(2'd1, 32'h1);
        busRead(2'd1, rd); checkOutput("mask_rb", rd, 32'h1);
        address = 2'd0;
        applyStimulus(8'hFE);
        tick(5);
        checkOutput("press_e5_data", readdata, 32'h0000_00FF);
        checkOutput("press_e5_irq", {31'h0, irq}, 32'h0);
        address = 2'd2;
        tick(1);
        checkOutput("press_e6_edge_prev", readdata, 32'h0);
        checkOutput("press_e6_irq", {31'h0, irq}, 32'h1);
        address = 2'd0;
        tick(1);
        checkOutput("press_e7_data", readdata, 32'h0000_00FE);
        address = 2'd2;
        tick(1);
        checkOutput("press_edge", readdata, 32'h1);

        // W1C clear; readdata shows the pre-write value
        busWrite(2'd2, 32'h1);
        checkOutput("clr_prewrite", readdata, 32'h1);
        checkOutput("clr_irq", {31'h0, irq}, 32'h0);
        busRead(2'd2, rd); checkOutput("clr_edge", rd, 32'h0);

        // release: only flagged when any-edge capture is built in
        address = 2'd0;
        applyStimulus(8'hFF);
        tick(7);
        checkOutput("rel_data", readdata, 32'h0000_00FF);
        busRead(2'd2, rd);
`ifdef NIOSII_BUTS_ANY_EDGE_EN
        checkOutput("rel_edge", rd, 32'h1);
        checkOutput("rel_irq", {31'h0, irq}, 32'h1);
`else
        checkOutput("rel_edge", rd, 32'h0);
        checkOutput("rel_irq", {31'h0, irq}, 32'h0);
`endif
        busWrite(2'd2, 32'h1);
        checkOutput("rel_clr_irq", {31'h0, irq}, 32'h0);

        // new press lands on the same edge as a clear: set wins
        address = 2'd0;
        applyStimulus(8'hFE);
        tick(5);
        busWrite(2'd2, 32'h1);
        checkOutput("setwin_prewrite", readdata, 32'h0);
        checkOutput("setwin_irq", {31'h0, irq}, 32'h1);
        busRead(2'd2, rd); checkOutput("setwin_edge", rd, 32'h1);

        // build EDGECAP=0x05 with a press of bit 2
        address = 2'd0;
        applyStimulus(8'hFA);
        tick(7);
        checkOutput("b2_data", readdata, 32'h0000_00FA);
        busRead(2'd2, rd); checkOutput("b2_edge", rd, 32'h5);

        // reset while bit 1 is mid-debounce (cnt=2)
        address = 2'd0;
        applyStimulus(8'hF8);
        tick(4);
        reset = 1'b1;
        applyStimulus(8'hFF);
        tick(1);
        checkOutput("mid_rst_readdata", readdata, 32'h0);
        checkOutput("mid_rst_irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;
        busRead(2'd0, rd); checkOutput("mid_rst_data", rd, 32'h0000_00FF);
        busRead(2'd1, rd); checkOutput("mid_rst_mask", rd, 32'h0);
        busRead(2'd2, rd); checkOutput("mid_rst_edge", rd, 32'h0);
        busRead(2'd3, rd); checkOutput("mid_rst_period", rd, 32'd50000);
        tick(10);
        busRead(2'd2, rd); checkOutput("post_rst_edge", rd, 32'h0);
        checkOutput("post_rst_irq", {31'h0, irq}, 32'h0);

        // DBPERIOD=0 behaves as 1: stable after 3 edges, masked irq stays low
        busWrite(2'd3, 32'h0);
        busRead(2'd3, rd); checkOutput("p0_rb", rd, 32'h0);
        address = 2'd0;
        applyStimulus(8'hF7);
        tick(3);
        checkOutput("p0_e3_data", readdata, 32'h0000_00FF);
        tick(1);
        checkOutput("p0_e4_data", readdata, 32'h0000_00F7);
        busRead(2'd2, rd); checkOutput("p0_edge", rd, 32'h8);
        checkOutput("p0_irq_masked", {31'h0, irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
